// File: rtl/proc_tb_pkg.sv
// proc_tb_pkg
// Shared definitions for processor run/bring-up harnesses.
//   run_state_t        : run controller state encoding
//   DEFAULT_HALT_INSTR : all-ones halt encoding for a 32-bit instruction bus
package proc_tb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESET_DUT = 2'd1,
    RUN       = 2'd2,
    DONE      = 2'd3
  } run_state_t;

  localparam logic [31:0] DEFAULT_HALT_INSTR = 32'hFFFF_FFFF;

endpackage

// File: rtl/proc_run_ctrl_sat_counter.sv
// sat_counter
// Loadable counter that stops at a bound instead of wrapping.
// Counts up to LIMIT, or down to 0 when DOWN is set.
// Ports:
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (has priority over en)
//   load_val   : value loaded on load
//   en         : step the counter by one towards its bound
//   count      : current value
//   at_limit   : count sits at its bound (LIMIT, or 0 when counting down)
module sat_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = 255,
  parameter bit          DOWN  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] STOP = DOWN ? '0 : WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != STOP)) begin
      count_d = DOWN ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign at_limit = (count_q == STOP);

endmodule

// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl
// Run controller around the Processor: holds it in reset for RST_CYCLES after
// a start, lets it run until halt, abort or the cycle budget, then latches and
// grades its output against the expected value.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : run request, accepted in IDLE or DONE
//   abort        : end the run early (graded as timeout), RUN only
//   expected     : golden result, captured on an accepted start
//   dut_out      : processor_out
//   dut_instr    : instruction fetched by the processor
//   dut_reset    : reset to the processor (low only in RUN)
//   busy         : RESET_DUT or RUN
//   done         : DONE
//   pass/timeout : verdict, valid while done
//   result       : dut_out captured in the ending RUN cycle
//   cycle_count  : RUN cycles consumed, including the ending one
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | waiting for start, processor held in reset
// RESET_DUT | holding processor reset for RST_CYCLES cycles
// RUN       | processor released, counting cycles
// DONE      | run finished, verdict held, processor frozen
module proc_run_ctrl
  import proc_tb_pkg::*;
#(
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        INSTR_W    = 32,
  parameter int unsigned        RST_CYCLES = 1,
  parameter int unsigned        MAX_CYCLES = 100,
  parameter logic [INSTR_W-1:0] HALT_INSTR = {INSTR_W{1'b1}},
  parameter int unsigned        CNT_W      = $clog2(MAX_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [DATA_W-1:0]  expected,
  input  logic [DATA_W-1:0]  dut_out,
  input  logic [INSTR_W-1:0] dut_instr,
  output logic               dut_reset,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [DATA_W-1:0]  result,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);

  run_state_t        state_q, state_d;
  logic              dut_reset_q, dut_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] exp_q, exp_d;

  logic             start_acc;
  logic [RST_W-1:0] rst_cnt;
  logic             rst_zero;
  logic [CNT_W-1:0] run_cnt;
  logic             run_sat;
  logic             halt_hit, budget_hit, end_run;

  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
  assign halt_hit  = (dut_instr == HALT_INSTR);
  // run_cnt holds cycles already completed, so the current cycle is the last
  // one of the budget when run_cnt == MAX_CYCLES-1. run_sat is a backstop.
  assign budget_hit = (run_cnt == CNT_W'(MAX_CYCLES - 1)) || run_sat;
  assign end_run    = abort || halt_hit || budget_hit;

  sat_counter #(
    .WIDTH (RST_W),
    .LIMIT (0),
    .DOWN  (1'b1)
  ) u_rst_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (start_acc),
    .load_val (RST_W'(RST_CYCLES - 1)),
    .en       (state_q == RESET_DUT),
    .count    (rst_cnt),
    .at_limit (rst_zero)
  );

  sat_counter #(
    .WIDTH (CNT_W),
    .LIMIT (MAX_CYCLES),
    .DOWN  (1'b0)
  ) u_run_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (start_acc),
    .load_val ('0),
    .en       (state_q == RUN),
    .count    (run_cnt),
    .at_limit (run_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dut_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      result_q    <= '0;
      exp_q       <= '0;
    end else begin
      state_q     <= state_d;
      dut_reset_q <= dut_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      result_q    <= result_d;
      exp_q       <= exp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start_acc) state_d = RESET_DUT;
      RESET_DUT:  if (rst_zero)  state_d = RUN;
      RUN:        if (end_run)   state_d = DONE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    dut_reset_d = (state_d != RUN);
    busy_d      = (state_d == RESET_DUT) || (state_d == RUN);
    done_d      = (state_d == DONE);
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    result_d    = result_q;
    exp_d       = exp_q;
    if (start_acc) begin
      exp_d     = expected;
      result_d  = '0;
      pass_d    = 1'b0;
      timeout_d = 1'b0;
    end else if ((state_q == RUN) && end_run) begin
      result_d  = dut_out;
      // abort outranks halt; any other non-halt ending is the budget
      timeout_d = abort || !halt_hit;
      pass_d    = !timeout_d && (dut_out == exp_q);
    end
  end

  assign dut_reset   = dut_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign result      = result_q;
  assign cycle_count = run_cnt;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb_proc_run_ctrl
// Directed and randomized runs of proc_run_ctrl against a run-outcome model
// that predicts the ending cycle and verdict from halt/abort/reset positions.
module tb_proc_run_ctrl;
  import proc_tb_pkg::*;

  localparam int DW  = 32;
  localparam int IW  = 32;
  localparam int RST = 3;
  localparam int MAX = 100;
  localparam int CW  = $clog2(MAX + 1);
  localparam logic [IW-1:0] HALT = DEFAULT_HALT_INSTR;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [DW-1:0] expected, dut_out;
  logic [IW-1:0] dut_instr;
  logic          dut_reset, busy, done, pass, timeout;
  logic [DW-1:0] result;
  logic [CW-1:0] cycle_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  proc_run_ctrl #(
    .DATA_W     (DW),
    .INSTR_W    (IW),
    .RST_CYCLES (RST),
    .MAX_CYCLES (MAX),
    .HALT_INSTR (HALT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .expected    (expected),
    .dut_out     (dut_out),
    .dut_instr   (dut_instr),
    .dut_reset   (dut_reset),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .result      (result),
    .cycle_count (cycle_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which RUN cycle ends the run and how it is graded. A reset in or before
  // the ending cycle wins and discards the run.
  function automatic void predict(input int halt_k, input int abort_k, input int reset_k,
                                  output int end_k, output bit to, output bit rst_hit);
    end_k = MAX;
    if (halt_k > 0 && halt_k < end_k)   end_k = halt_k;
    if (abort_k > 0 && abort_k < end_k) end_k = abort_k;
    if (abort_k == end_k)     to = 1'b1;
    else if (halt_k == end_k) to = 1'b0;
    else                      to = 1'b1;
    rst_hit = (reset_k > 0 && reset_k <= end_k);
    if (rst_hit) end_k = reset_k;
  endfunction

  task automatic status_idle(input string nm);
    chk({nm, ".dut_reset"}, 64'(dut_reset), 64'(1));
    chk({nm, ".busy"}, 64'(busy), 64'(0));
    chk({nm, ".done"}, 64'(done), 64'(0));
    chk({nm, ".pass"}, 64'(pass), 64'(0));
    chk({nm, ".timeout"}, 64'(timeout), 64'(0));
    chk({nm, ".result"}, 64'(result), 64'(0));
    chk({nm, ".cycle_count"}, 64'(cycle_count), 64'(0));
  endtask

  // Called at a negedge with the controller in IDLE or DONE.
  task automatic run_case(input string nm, input logic [DW-1:0] exp_v, input int halt_k,
                          input logic [DW-1:0] halt_v, input int abort_k, input int reset_k,
                          input int start_k, input bit abort_pre);
    int            end_k;
    bit            to, rst_hit, exp_pass;
    logic [DW-1:0] end_val, o;
    logic [IW-1:0] ins;
    predict(halt_k, abort_k, reset_k, end_k, to, rst_hit);
    end_val = '0;

    start = 1'b1; expected = exp_v; abort = abort_pre;
    @(negedge clk);
    start = 1'b0; expected = $urandom;
    chk({nm, ".start_busy"}, 64'(busy), 64'(1));
    chk({nm, ".start_done"}, 64'(done), 64'(0));
    chk({nm, ".start_pass"}, 64'(pass), 64'(0));
    chk({nm, ".start_timeout"}, 64'(timeout), 64'(0));
    chk({nm, ".start_result"}, 64'(result), 64'(0));
    chk({nm, ".start_cnt"}, 64'(cycle_count), 64'(0));
    chk({nm, ".hold_rst1"}, 64'(dut_reset), 64'(1));
    for (int i = 2; i <= RST; i++) begin
      @(negedge clk);
      chk({nm, ".hold_rst"}, 64'(dut_reset), 64'(1));
    end
    @(negedge clk);
    abort = 1'b0;
    chk({nm, ".released"}, 64'(dut_reset), 64'(0));
    chk({nm, ".run_cnt0"}, 64'(cycle_count), 64'(0));

    for (int k = 1; k <= end_k; k++) begin
      if (k == halt_k) begin
        ins = HALT; o = halt_v;
      end else begin
        ins = $urandom; o = $urandom;
        if (ins == HALT) ins = '0;
      end
      dut_instr = ins; dut_out = o;
      abort = (k == abort_k); reset = (k == reset_k); start = (k == start_k);
      if (k == end_k) end_val = o;
      @(negedge clk);
      if (k < end_k) begin
        chk({nm, ".run_cnt"}, 64'(cycle_count), 64'(k));
        chk({nm, ".run_busy"}, 64'(busy), 64'(1));
      end
    end
    abort = 1'b0; reset = 1'b0; start = 1'b0; dut_instr = '0; dut_out = '0;

    if (rst_hit) begin
      status_idle({nm, ".reset"});
    end else begin
      exp_pass = !to && (end_val == exp_v);
      chk({nm, ".done"}, 64'(done), 64'(1));
      chk({nm, ".busy"}, 64'(busy), 64'(0));
      chk({nm, ".dut_reset"}, 64'(dut_reset), 64'(1));
      chk({nm, ".timeout"}, 64'(timeout), 64'(to));
      chk({nm, ".pass"}, 64'(pass), 64'(exp_pass));
      chk({nm, ".result"}, 64'(result), 64'(end_val));
      chk({nm, ".cycle_count"}, 64'(cycle_count), 64'(end_k));
      @(negedge clk);
      chk({nm, ".hold_done"}, 64'(done), 64'(1));
      chk({nm, ".hold_result"}, 64'(result), 64'(end_val));
      chk({nm, ".hold_pass"}, 64'(pass), 64'(exp_pass));
    end
  endtask

  initial begin
    int            hk, ak, rk;
    logic [DW-1:0] ev, hv;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    expected = 32'hDEAD_BEEF; dut_out = '0; dut_instr = '0;
    repeat (3) @(negedge clk);
    status_idle("por");
    reset = 1'b0;
    @(negedge clk);
    status_idle("idle");

    run_case("halt",       32'd55, 20,  32'd55, 0, 0, 0,  1'b0);
    run_case("mismatch",   32'd55, 20,  32'd54, 0, 0, 0,  1'b0);
    run_case("budget",     32'd9,  0,   32'd0,  0, 0, 0,  1'b0);
    run_case("halt_last",  32'd7,  MAX, 32'd7,  0, 0, 0,  1'b0);
    run_case("start_run",  32'd3,  30,  32'd3,  0, 0, 10, 1'b1);
    run_case("abort",      32'd1,  0,   32'd0,  7, 0, 0,  1'b0);
    run_case("abort_halt", 32'd4,  12,  32'd4,  12, 0, 0, 1'b0);
    run_case("back2back",  32'd10, 5,   32'd10, 0, 0, 0,  1'b0);
    run_case("reset_run",  32'd2,  0,   32'd0,  0, 7, 0,  1'b0);
    run_case("after_rst",  32'd21, 3,   32'd21, 0, 0, 0,  1'b0);

    for (int n = 0; n < 16; n++) begin
      ev = $urandom;
      hv = ($urandom_range(0, 1) == 0) ? ev : DW'($urandom);
      hk = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, MAX));
      ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MAX)) : 0;
      rk = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, MAX)) : 0;
      run_case("rand", ev, hk, hv, ak, rk, int'($urandom_range(0, MAX)),
               1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
